// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, fill word, word lengths.
package spi_responder_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam logic [31:0] FillWord = 32'hFFFF_FFFF;
  localparam logic [5:0]  ByteLen  = 6'd8;
  localparam logic [5:0]  WideLen  = 6'd32;

  // Number of bits in a word for the selected width.
  function automatic logic [5:0] word_len(input logic wide);
    return wide ? WideLen : ByteLen;
  endfunction

  // Left-align the outgoing word so the MSB always sits in bit 31.
  function automatic logic [31:0] align_tx(input logic [31:0] word, input logic wide);
    return wide ? word : {word[7:0], 24'hFF_FFFF};
  endfunction

endpackage

// File: rtl/spi_responder_sync_ff2.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sync_ff2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back capture stages; resetting to zero keeps a low SS_n from
  // looking like a fresh fall after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with oversampled pins, one-word TX holding and RX registers.
module spi_responder
  import spi_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wide,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [31:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        rx_overrun,
  output logic        busy
);

  logic [2:0] pins_s;
  logic       sclk_s, mosi_s, ss_s;

  sync_ff2 #(.Width(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({SCLK, MOSI, SS_n}),
    .q   (pins_s)
  );

  assign {sclk_s, mosi_s, ss_s} = pins_s;

  state_e      state_q, state_d;
  logic        sclk_d3_q, ss_d3_q;
  logic        wide_q, wide_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic [31:0] rx_sh_q, rx_sh_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        busy_q, busy_d;
  logic        word_done_q, word_done_d;

  logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic        shift_load, rx_end, wide_sel;
  logic [31:0] rx_sh_next;

  assign sclk_rise = sclk_s & ~sclk_d3_q;
  assign sclk_fall = ~sclk_s & sclk_d3_q;
  assign ss_rise   = ss_s & ~ss_d3_q;
  assign ss_fall   = ~ss_s & ss_d3_q;
  assign rx_sh_next = {rx_sh_q[30:0], mosi_s};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      sclk_d3_q    <= 1'b0;
      ss_d3_q      <= 1'b0;
      wide_q       <= 1'b0;
      cnt_q        <= '0;
      tx_sh_q      <= FillWord;
      rx_sh_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_d3_q    <= sclk_s;
      ss_d3_q      <= ss_s;
      wide_q       <= wide_d;
      cnt_q        <= cnt_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
    end
  end

  // FSM next state, shifters, bit counter, holding and receive registers.
  always_comb begin
    state_d      = state_q;
    wide_d       = wide_q;
    cnt_d        = cnt_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    busy_d       = busy_q;
    word_done_d  = word_done_q;
    shift_load   = 1'b0;
    rx_end       = 1'b0;
    wide_sel     = wide_q;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d     = StShift;
          wide_d      = wide;
          wide_sel    = wide;
          cnt_d       = '0;
          busy_d      = 1'b0;
          word_done_d = 1'b0;
          shift_load  = 1'b1;
        end
      end
      StShift: begin
        if (ss_rise) begin
          // Abort: drop any partial word.
          state_d     = StIdle;
          cnt_d       = '0;
          busy_d      = 1'b0;
          word_done_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_sh_d = rx_sh_next;
            if (cnt_q + 6'd1 == word_len(wide_q)) begin
              cnt_d       = '0;
              busy_d      = 1'b0;
              word_done_d = 1'b1;
              rx_end      = 1'b1;
              rx_data_d   = wide_q ? rx_sh_next : {24'b0, rx_sh_next[7:0]};
            end else begin
              cnt_d  = cnt_q + 6'd1;
              busy_d = 1'b1;
            end
          end
          if (sclk_fall) begin
            if (word_done_q) begin
              // Back-to-back word: re-sample width and reload.
              wide_d      = wide;
              wide_sel    = wide;
              word_done_d = 1'b0;
              shift_load  = 1'b1;
            end else begin
              tx_sh_d = {tx_sh_q[30:0], 1'b1};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (shift_load) begin
      tx_sh_d = align_tx(hold_full_q ? hold_q : FillWord, wide_sel);
    end

    // A load in the same cycle as consumption keeps the register full.
    if (tx_load) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (shift_load && hold_full_q) begin
      hold_full_d = 1'b0;
    end

    if (rx_end) begin
      rx_valid_d   = 1'b1;
      rx_overrun_d = rx_ack ? 1'b0 : (rx_overrun_q | rx_valid_q);
    end else if (rx_ack) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
  end

  assign MISO       = (state_q == StShift) ? tx_sh_q[31] : 1'b1;
  assign MISO_oe    = (state_q == StShift);
  assign tx_ready   = ~hold_full_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a behavioural SPI master with fixed timing.
module tb_spi_responder;

  localparam int H = 6;  // SCLK half-period in clk cycles

  logic        clk = 1'b0;
  logic        rst, wide, SCLK, MOSI, SS_n;
  logic        MISO, MISO_oe;
  logic [31:0] tx_data;
  logic        tx_load, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ack, rx_overrun, busy;

  int checks = 0;
  int errors = 0;

  spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .wide       (wide),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .SS_n       (SS_n),
    .MISO       (MISO),
    .MISO_oe    (MISO_oe),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [31:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  // Shift n bits MSB first; returns with SCLK still high after the last rise.
  task automatic spi_shift(input int n, input logic [31:0] mosi_w, output logic [31:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = mosi_w[n-1-i];
      tick(H);
      SCLK = 1'b1;
      miso_w = {miso_w[30:0], MISO};
      if (i != n - 1) begin
        tick(H);
        SCLK = 1'b0;
      end
    end
  endtask

  task automatic ss_start(input logic w);
    wide = w;
    SS_n = 1'b0;
    tick(H);
  endtask

  // SS_n rises before the final SCLK fall so no reload happens.
  task automatic ss_end();
    tick(H);
    SS_n = 1'b1;
    tick(H);
    SCLK = 1'b0;
    tick(H);
  endtask

  task automatic xfer(input logic w, input int n, input logic [31:0] mosi_w,
                      output logic [31:0] miso_w);
    ss_start(w);
    spi_shift(n, mosi_w, miso_w);
    ss_end();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_miso"}, MISO, 1'b1);
    check_eq({tag, "_oe"}, MISO_oe, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_ovr"}, rx_overrun, 1'b0);
    check_eq({tag, "_txrdy"}, tx_ready, 1'b1);
    check_eq({tag, "_rxv"}, rx_valid, 1'b0);
    check_eq({tag, "_rxd"}, rx_data, 32'h0);
  endtask

  logic [31:0] m;

  initial begin
    rst = 1'b0; wide = 1'b0; SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
    tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
    tick(3);
    check_reset_vals("rst");
    rst = 1'b1;
    tick(3);

    // Byte exchange with rx_valid latency.
    load_tx(32'h0000_00A5);
    check_eq("byte_txrdy_full", tx_ready, 1'b0);
    ss_start(1'b0);
    check_eq("byte_oe", MISO_oe, 1'b1);
    check_eq("byte_txrdy_after", tx_ready, 1'b1);
    spi_shift(8, 32'h3C, m);
    tick(2);
    check_eq("byte_rxv_early", rx_valid, 1'b0);
    check_eq("byte_busy_mid", busy, 1'b1);
    tick(1);
    check_eq("byte_rxv_3cyc", rx_valid, 1'b1);
    check_eq("byte_busy_end", busy, 1'b0);
    tick(3);
    SS_n = 1'b1;
    tick(H);
    SCLK = 1'b0;
    tick(H);
    check_eq("byte_miso_word", m, 32'hA5);
    check_eq("byte_rxd", rx_data, 32'h3C);
    check_eq("byte_oe_off", MISO_oe, 1'b0);
    check_eq("byte_miso_idle", MISO, 1'b1);
    ack();
    check_eq("byte_ack", rx_valid, 1'b0);

    // Wide back-to-back words, second load mid-word, overrun without ack.
    load_tx(32'hDEAD_BEEF);
    ss_start(1'b1);
    load_tx(32'h1234_5678);
    spi_shift(32, 32'h0102_0304, m);
    check_eq("wide_miso0", m, 32'hDEAD_BEEF);
    tick(H);
    check_eq("wide_rxd0", rx_data, 32'h0102_0304);
    SCLK = 1'b0;
    spi_shift(32, 32'hCAFE_F00D, m);
    ss_end();
    check_eq("wide_miso1", m, 32'h1234_5678);
    check_eq("wide_rxd1", rx_data, 32'hCAFE_F00D);
    check_eq("wide_ovr", rx_overrun, 1'b1);
    check_eq("wide_txrdy", tx_ready, 1'b1);
    ack();
    check_eq("wide_ack_ovr", rx_overrun, 1'b0);

    // Underrun: nothing held, wide transfer sends fill.
    xfer(1'b1, 32, 32'h0, m);
    check_eq("under_miso", m, 32'hFFFF_FFFF);
    check_eq("under_rxd", rx_data, 32'h0);
    ack();

    // Abort after 5 rises, then a clean byte.
    ss_start(1'b0);
    spi_shift(5, 32'h1F, m);
    tick(H);
    check_eq("abort_busy_mid", busy, 1'b1);
    SS_n = 1'b1;
    tick(H);
    SCLK = 1'b0;
    tick(H);
    check_eq("abort_rxv", rx_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_oe", MISO_oe, 1'b0);
    xfer(1'b0, 8, 32'h81, m);
    check_eq("abort_next_rxd", rx_data, 32'h81);
    check_eq("abort_next_rxv", rx_valid, 1'b1);
    check_eq("abort_next_miso", m, 32'hFF);

    // Overrun, then rx_ack coinciding with word end.
    xfer(1'b0, 8, 32'h42, m);
    check_eq("ovr_set", rx_overrun, 1'b1);
    ss_start(1'b0);
    spi_shift(8, 32'h7E, m);
    tick(2);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check_eq("ackend_rxv", rx_valid, 1'b1);
    check_eq("ackend_ovr", rx_overrun, 1'b0);
    check_eq("ackend_rxd", rx_data, 32'h7E);
    ss_end();
    ack();

    // tx_load on the shifter-load cycle.
    load_tx(32'h11);
    wide = 1'b0;
    SS_n = 1'b0;
    tick(2);
    tx_data = 32'h22;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    check_eq("ldsim_txrdy", tx_ready, 1'b0);
    tick(H - 3);
    spi_shift(8, 32'h0, m);
    ss_end();
    check_eq("ldsim_miso_old", m, 32'h11);
    check_eq("ldsim_txrdy_held", tx_ready, 1'b0);
    xfer(1'b0, 8, 32'h0, m);
    check_eq("ldsim_miso_new", m, 32'h22);
    check_eq("ldsim_txrdy_end", tx_ready, 1'b1);

    // Reset during bit 12 of a wide word with state set everywhere.
    ss_start(1'b1);
    load_tx(32'h99);
    spi_shift(12, 32'hABC, m);
    check_eq("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    SS_n = 1'b1;
    SCLK = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    xfer(1'b0, 8, 32'h55, m);
    check_eq("post_rst_rxd", rx_data, 32'h55);
    check_eq("post_rst_miso", m, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
